// File: rtl/clkdiv_monitor_if.sv
// Bundle between a divided-clock source and clkdiv_monitor.
//   div_in, clr_err      : stimulus toward the monitor
//   rise_pulse/fall_pulse: edge strobes from the monitor
//   period/period_valid  : last measured period and its update strobe
//   locked, err, err_count: lock status and fault reporting
interface clkdiv_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             div_in;
    logic             clr_err;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             err;
    logic [7:0]       err_count;

    modport master (
        output div_in, clr_err,
        input  rise_pulse, fall_pulse, period, period_valid, locked, err, err_count
    );

    modport slave (
        input  div_in, clr_err,
        output rise_pulse, fall_pulse, period, period_valid, locked, err, err_count
    );
endinterface

// File: rtl/clkdiv_monitor.sv
// Samples a divided clock as data, strobes its edges, measures period and
// high/low phases, tracks lock and counts ratio/duty/stuck faults.
//   clk  : single clock, rising edge
//   rst_ : synchronous reset, active-high
//   mon  : slave side of clkdiv_monitor_if (see interface for signal list)
module clkdiv_monitor #(
    parameter int unsigned DIV_RATIO  = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input logic             clk,
    input logic             rst_,
    clkdiv_monitor_if.slave mon
);
    localparam int unsigned GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  HALF_C     = CNT_W'(DIV_RATIO / 2);
    localparam logic [CNT_W-1:0]  FULL_C     = CNT_W'(DIV_RATIO);
    localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] LOCK_M1_C  = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic              d_q;
    logic [CNT_W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              pv_q, pv_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [7:0]        errc_q, errc_d;

    logic              err_event;
    logic [CNT_W-1:0]  hi_inc, lo_inc;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q  <= S_IDLE;
            d_q      <= 1'b1;   // a level already high at release is not a rise
            hi_q     <= '0;
            lo_q     <= '0;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= mon.div_in;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            good_q   <= good_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
        end
    end

    // Measurement, lock tracking and fault accounting
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        good_d    = good_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        locked_d  = locked_q;
        err_event = 1'b0;
        rise_d    = mon.div_in & ~d_q;
        fall_d    = ~mon.div_in & d_q;
        hi_inc    = hi_q + CNT_W'(1);
        lo_inc    = lo_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (rise_d) begin
                    hi_d    = CNT_W'(1);
                    lo_d    = '0;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE, S_LOCKED: begin
                if (rise_d) begin
                    period_d = hi_q + lo_q;
                    pv_d     = 1'b1;
                    hi_d     = CNT_W'(1);
                    lo_d     = '0;
                    if (hi_q == HALF_C && lo_q == HALF_C) begin
                        // good_cnt stays saturated once locked
                        if (state_q == S_MEASURE) begin
                            if (good_q == LOCK_M1_C) begin
                                good_d   = LOCK_C;
                                state_d  = S_LOCKED;
                                locked_d = 1'b1;
                            end else begin
                                good_d = good_q + GOOD_W'(1);
                            end
                        end
                    end else begin
                        err_event = 1'b1;
                        good_d    = '0;
                        locked_d  = 1'b0;
                        state_d   = S_MEASURE;
                    end
                end else if ((mon.div_in && hi_inc == FULL_C) ||
                             (!mon.div_in && lo_inc == FULL_C)) begin
                    // Phase twice its expected length: treat as stuck
                    err_event = 1'b1;
                    state_d   = S_IDLE;
                    hi_d      = '0;
                    lo_d      = '0;
                    good_d    = '0;
                    locked_d  = 1'b0;
                end else if (mon.div_in) begin
                    hi_d = hi_inc;
                end else begin
                    lo_d = lo_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear first so a coincident error leaves err=1, err_count=1
        err_d  = err_q;
        errc_d = errc_q;
        if (mon.clr_err) begin
            err_d  = 1'b0;
            errc_d = '0;
        end
        if (err_event) begin
            err_d = 1'b1;
            if (errc_d != 8'hFF) begin
                errc_d = errc_d + 8'd1;
            end
        end
    end

    assign mon.rise_pulse   = rise_q;
    assign mon.fall_pulse   = fall_q;
    assign mon.period       = period_q;
    assign mon.period_valid = pv_q;
    assign mon.locked       = locked_q;
    assign mon.err          = err_q;
    assign mon.err_count    = errc_q;
endmodule
